// File: rtl/prog_run_ctrl_if.sv
// Signal bundle between the ALU-test sequencer and its surroundings: the
// front end (start/operands/status), the instruction loader and the core.
// slave:  the sequencer's own view.
// master: the view of whatever drives the sequencer (front end, loader, core).
interface prog_run_ctrl_if;
    // Front-end request
    logic        start;
    logic [7:0]  op1;
    logic [7:0]  op2;
    logic [2:0]  alu_op;
    // Loader control
    logic        ldr_rst_n;
    logic [7:0]  ldr_op1;
    logic [7:0]  ldr_op2;
    logic [2:0]  ldr_alu_op;
    logic        ldr_done;
    // Core control and register-file debug port
    logic        cpu_rst_n;
    logic        cpu_stall;
    logic [4:0]  dbg_raddr;
    logic [31:0] dbg_rdata;
    // Status
    logic        busy;
    logic [31:0] result;
    logic        result_valid;
    logic        timeout_err;

    modport slave (
        input  start, op1, op2, alu_op, ldr_done, dbg_rdata,
        output ldr_rst_n, ldr_op1, ldr_op2, ldr_alu_op, cpu_rst_n, cpu_stall,
               dbg_raddr, busy, result, result_valid, timeout_err
    );

    modport master (
        output start, op1, op2, alu_op, ldr_done, dbg_rdata,
        input  ldr_rst_n, ldr_op1, ldr_op2, ldr_alu_op, cpu_rst_n, cpu_stall,
               dbg_raddr, busy, result, result_valid, timeout_err
    );
endinterface

// File: rtl/prog_run_ctrl.sv
// Sequencer for one ALU test on the core: load the program with the core held
// in reset, let the core run for a fixed window, freeze it and read r11.
// Owns the resets of both the instruction loader and the core.
module prog_run_ctrl #(
    parameter int unsigned RUN_CYCLES   = 16,
    parameter int unsigned LOAD_TIMEOUT = 32
) (
    input logic             clk,
    input logic             rst,
    prog_run_ctrl_if.slave  bus
);

    localparam int unsigned LCW = (LOAD_TIMEOUT > 1) ? $clog2(LOAD_TIMEOUT) : 1;
    localparam int unsigned RCW = (RUN_CYCLES > 1) ? $clog2(RUN_CYCLES) : 1;
    localparam logic [LCW-1:0] LOAD_LAST = LCW'(LOAD_TIMEOUT - 1);
    localparam logic [RCW-1:0] RUN_LAST  = RCW'(RUN_CYCLES - 1);
    localparam logic [4:0]     RESULT_REG = 5'd11;

    typedef enum logic [1:0] {StIdle, StLoad, StRun, StRead} state_e;

    state_e      state_q, state_d;
    logic [LCW-1:0] load_cnt_q, load_cnt_d;
    logic [RCW-1:0] run_cnt_q, run_cnt_d;
    logic        ldr_rst_n_q, ldr_rst_n_d;
    logic        cpu_rst_n_q, cpu_rst_n_d;
    logic        cpu_stall_q, cpu_stall_d;
    logic        busy_q, busy_d;
    logic [31:0] result_q, result_d;
    logic        result_valid_q, result_valid_d;
    logic        timeout_err_q, timeout_err_d;
    logic [7:0]  op1_q, op1_d;
    logic [7:0]  op2_q, op2_d;
    logic [2:0]  alu_op_q, alu_op_d;

    // State and registered outputs; synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= StIdle;
            load_cnt_q     <= '0;
            run_cnt_q      <= '0;
            ldr_rst_n_q    <= 1'b0;
            cpu_rst_n_q    <= 1'b0;
            cpu_stall_q    <= 1'b0;
            busy_q         <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            timeout_err_q  <= 1'b0;
            op1_q          <= '0;
            op2_q          <= '0;
            alu_op_q       <= '0;
        end else begin
            state_q        <= state_d;
            load_cnt_q     <= load_cnt_d;
            run_cnt_q      <= run_cnt_d;
            ldr_rst_n_q    <= ldr_rst_n_d;
            cpu_rst_n_q    <= cpu_rst_n_d;
            cpu_stall_q    <= cpu_stall_d;
            busy_q         <= busy_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            timeout_err_q  <= timeout_err_d;
            op1_q          <= op1_d;
            op2_q          <= op2_d;
            alu_op_q       <= alu_op_d;
        end
    end

    // Next-state and next-output decode; the two status pulses default low.
    always_comb begin
        state_d        = state_q;
        load_cnt_d     = load_cnt_q;
        run_cnt_d      = run_cnt_q;
        ldr_rst_n_d    = ldr_rst_n_q;
        cpu_rst_n_d    = cpu_rst_n_q;
        cpu_stall_d    = cpu_stall_q;
        busy_d         = busy_q;
        result_d       = result_q;
        result_valid_d = 1'b0;
        timeout_err_d  = 1'b0;
        op1_d          = op1_q;
        op2_d          = op2_q;
        alu_op_d       = alu_op_q;

        case (state_q)
            StIdle: begin
                ldr_rst_n_d = 1'b0;
                cpu_rst_n_d = 1'b0;
                cpu_stall_d = 1'b0;
                busy_d      = 1'b0;
                if (bus.start) begin
                    op1_d       = bus.op1;
                    op2_d       = bus.op2;
                    alu_op_d    = bus.alu_op;
                    busy_d      = 1'b1;
                    ldr_rst_n_d = 1'b1;
                    load_cnt_d  = '0;
                    state_d     = StLoad;
                end
            end

            StLoad: begin
                cpu_rst_n_d = 1'b0;
                // Done takes priority over a timeout landing in the same cycle.
                if (bus.ldr_done) begin
                    cpu_rst_n_d = 1'b1;
                    run_cnt_d   = '0;
                    state_d     = StRun;
                end else if (load_cnt_q == LOAD_LAST) begin
                    timeout_err_d = 1'b1;
                    busy_d        = 1'b0;
                    ldr_rst_n_d   = 1'b0;
                    state_d       = StIdle;
                end else begin
                    load_cnt_d = load_cnt_q + LCW'(1);
                end
            end

            StRun: begin
                // Loader stays out of reset so it holds done and does not reload.
                if (run_cnt_q == RUN_LAST) begin
                    // Core leaves the run window: frozen and back in reset while
                    // the register file is read through the debug port.
                    cpu_stall_d = 1'b1;
                    cpu_rst_n_d = 1'b0;
                    state_d     = StRead;
                end else begin
                    run_cnt_d = run_cnt_q + RCW'(1);
                end
            end

            StRead: begin
                result_d       = bus.dbg_rdata;
                result_valid_d = 1'b1;
                busy_d         = 1'b0;
                cpu_stall_d    = 1'b0;
                cpu_rst_n_d    = 1'b0;
                ldr_rst_n_d    = 1'b0;
                state_d        = StIdle;
            end

            default: state_d = StIdle;
        endcase
    end

    assign bus.ldr_rst_n    = ldr_rst_n_q;
    assign bus.ldr_op1      = op1_q;
    assign bus.ldr_op2      = op2_q;
    assign bus.ldr_alu_op   = alu_op_q;
    assign bus.cpu_rst_n    = cpu_rst_n_q;
    assign bus.cpu_stall    = cpu_stall_q;
    assign bus.dbg_raddr    = RESULT_REG;
    assign bus.busy         = busy_q;
    assign bus.result       = result_q;
    assign bus.result_valid = result_valid_q;
    assign bus.timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_prog_run_ctrl.sv
// Bench for prog_run_ctrl. The reference model works on a timeline: each
// accepted test is described by its accept cycle and the loader delay, and
// every expected output in a cycle follows from plain arithmetic on those.
module tb_prog_run_ctrl;

    localparam int RUN_CYCLES   = 16;
    localparam int LOAD_TIMEOUT = 32;
    localparam int NEVER        = 1000;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    prog_run_ctrl_if bus ();

    prog_run_ctrl #(
        .RUN_CYCLES   (RUN_CYCLES),
        .LOAD_TIMEOUT (LOAD_TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;

    // Model state: one in-flight test at most.
    bit          act      = 1'b0;
    bit          has_done = 1'b0;
    int          t_acc    = 0;
    int          d_cur    = 0;
    int          end_cyc  = 0;
    logic [31:0] res_exp  = '0;
    logic [31:0] cap      = '0;
    logic [7:0]  e_op1    = '0;
    logic [7:0]  e_op2    = '0;
    logic [2:0]  e_alu    = '0;

    // Stimulus for the next cycle.
    bit          start_v = 1'b0;
    bit          rst_v   = 1'b0;
    logic [7:0]  op1_v   = '0;
    logic [7:0]  op2_v   = '0;
    logic [2:0]  alu_v   = '0;
    logic [31:0] rdata_v = '0;
    int          next_d  = 4;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s cycle %0d: got %h, want %h", tag, cyc, obs, exp);
        end
    endtask

    // Loader delay (cycles after release until done), mostly the conforming 4.
    function automatic int pick_d();
        int sel;
        sel = int'($urandom_range(0, 9));
        if (sel <= 5) return 4;
        if (sel == 6) return int'($urandom_range(0, LOAD_TIMEOUT - 1));
        if (sel == 7) return LOAD_TIMEOUT - 1;
        if (sel == 8) return NEVER;
        return int'($urandom_range(0, 12));
    endfunction

    task automatic step();
        int  dcyc;
        bit  busy_e, cpu_e, stall_e, rv_e, to_e;
        @(posedge clk);
        #1;
        cyc++;
        dcyc = t_acc + 1 + d_cur;
        if (act && has_done && cyc == end_cyc) res_exp = cap;

        busy_e  = act && (cyc < end_cyc);
        cpu_e   = act && has_done && (cyc >= dcyc + 1) && (cyc <= dcyc + RUN_CYCLES);
        stall_e = act && has_done && (cyc == dcyc + RUN_CYCLES + 1);
        rv_e    = act && has_done && (cyc == end_cyc);
        to_e    = act && !has_done && (cyc == end_cyc);

        check_eq("busy",         32'(bus.busy),         32'(busy_e));
        check_eq("ldr_rst_n",    32'(bus.ldr_rst_n),    32'(busy_e));
        check_eq("cpu_rst_n",    32'(bus.cpu_rst_n),    32'(cpu_e));
        check_eq("cpu_stall",    32'(bus.cpu_stall),    32'(stall_e));
        check_eq("result_valid", 32'(bus.result_valid), 32'(rv_e));
        check_eq("timeout_err",  32'(bus.timeout_err),  32'(to_e));
        check_eq("result",       bus.result,            res_exp);
        check_eq("ldr_op1",      32'(bus.ldr_op1),      32'(e_op1));
        check_eq("ldr_op2",      32'(bus.ldr_op2),      32'(e_op2));
        check_eq("ldr_alu_op",   32'(bus.ldr_alu_op),   32'(e_alu));
        check_eq("dbg_raddr",    32'(bus.dbg_raddr),    32'd11);

        // Drive inputs for this cycle; the loader holds done once raised.
        rst           = rst_v;
        bus.start     = start_v;
        bus.op1       = op1_v;
        bus.op2       = op2_v;
        bus.alu_op    = alu_v;
        bus.dbg_rdata = rdata_v;
        bus.ldr_done  = act && (cyc >= dcyc) && (cyc < end_cyc);

        if (rst_v && act && has_done && cyc == dcyc + RUN_CYCLES + 1) cap = rdata_v;

        if (!rst_v) begin
            act     = 1'b0;
            res_exp = '0;
            e_op1   = '0;
            e_op2   = '0;
            e_alu   = '0;
        end else begin
            if (act && cyc >= end_cyc) act = 1'b0;
            if (!act && start_v) begin
                act      = 1'b1;
                t_acc    = cyc;
                d_cur    = (next_d >= 0) ? next_d : pick_d();
                has_done = (d_cur <= LOAD_TIMEOUT - 1);
                end_cyc  = has_done ? (t_acc + d_cur + RUN_CYCLES + 3)
                                    : (t_acc + LOAD_TIMEOUT + 1);
                e_op1    = op1_v;
                e_op2    = op2_v;
                e_alu    = alu_v;
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        rst           = 1'b0;
        bus.start     = 1'b0;
        bus.op1       = '0;
        bus.op2       = '0;
        bus.alu_op    = '0;
        bus.ldr_done  = 1'b0;
        bus.dbg_rdata = '0;

        // Reset, then idle.
        rst_v = 1'b0;
        run(3);
        rst_v = 1'b1;
        run(5);

        // Single conforming test: 5, 3, op 0, r11 reads 8.
        op1_v = 8'd5; op2_v = 8'd3; alu_v = 3'd0; rdata_v = 32'h8; next_d = 4;
        start_v = 1'b1; run(1);
        start_v = 1'b0; run(26);

        // Loader never finishes.
        next_d = NEVER; op1_v = 8'd9;
        start_v = 1'b1; run(1);
        start_v = 1'b0; run(36);

        // start held high, operands wandering mid-test.
        rdata_v = 32'hFFFF_FFFE; next_d = 4; start_v = 1'b1;
        for (int i = 0; i < 60; i++) begin
            op1_v = 8'($urandom);
            op2_v = 8'($urandom);
            alu_v = 3'($urandom);
            run(1);
        end
        start_v = 1'b0; run(25);

        // Reset during RUN at T+10, then a fresh test.
        next_d = 4; op1_v = 8'd7; rdata_v = 32'h1234_5678;
        start_v = 1'b1; run(1);
        start_v = 1'b0; run(9);
        rst_v = 1'b0; run(1);
        rst_v = 1'b1; run(3);
        start_v = 1'b1; run(1);
        start_v = 1'b0; run(26);

        // Done arrives exactly on the last load-counter value.
        next_d = LOAD_TIMEOUT - 1; rdata_v = 32'hA5A5_0001;
        start_v = 1'b1; run(1);
        start_v = 1'b0; run(55);

        // Random traffic.
        next_d = -1;
        for (int i = 0; i < 3000; i++) begin
            start_v = ($urandom_range(0, 3) == 0);
            op1_v   = 8'($urandom);
            op2_v   = 8'($urandom);
            alu_v   = 3'($urandom);
            rdata_v = $urandom;
            rst_v   = ($urandom_range(0, 299) != 0);
            run(1);
        end
        rst_v = 1'b1; start_v = 1'b0;
        run(60);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
